// File: rtl/hazard_ctr_pkg.sv
// Shared pipeline definitions for the 5-stage core: register index type,
// NOP encoding and MDU timing defaults used by the interlock controller.
package hazard_ctr_pkg;

  localparam int MDU_LATENCY_DEF = 32;
  localparam int REG_IDX_W       = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/hazard_ctr_mdu_busy_timer.sv
// Countdown of outstanding mult/div latency; mdu_busy comes straight from
// the state register so it has no combinational path from any input.
//
// state    | meaning
// MDU_IDLE | mdu_cnt == 0, HI/LO valid
// MDU_BUSY | mdu_cnt != 0, HI/LO not yet valid
module mdu_busy_timer
  import hazard_ctr_pkg::*;
#(
  parameter int MDU_LATENCY = MDU_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic mdu_busy
);

  localparam int CW = $clog2(MDU_LATENCY + 1);
  localparam logic [CW-1:0] LAT = CW'(MDU_LATENCY);

  mdu_state_t    state;
  logic [CW-1:0] mdu_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= MDU_IDLE;
      mdu_cnt <= '0;
    end else if (issue) begin
      state   <= MDU_BUSY;
      mdu_cnt <= LAT;
    end else if (mdu_cnt != '0) begin
      mdu_cnt <= mdu_cnt - CW'(1);
      if (mdu_cnt == CW'(1)) state <= MDU_IDLE;
    end
  end

  assign mdu_busy = (state == MDU_BUSY);

endmodule

// File: rtl/hazard_ctr.sv
// Pipeline interlock: load-use and MDU-busy stalls, taken-branch flush,
// plus a saturating stall-cycle statistic.
module hazard_ctr
  import hazard_ctr_pkg::*;
#(
  parameter int MDU_LATENCY = MDU_LATENCY_DEF,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  reg_idx_t         if_id_rs,
  input  reg_idx_t         if_id_rt,
  input  logic             if_id_use_rs,
  input  logic             if_id_use_rt,
  input  logic             if_id_mdu_read,
  input  logic             if_id_mdu_start,
  input  reg_idx_t         id_ex_rt,
  input  logic             id_ex_memread_flag,
  input  logic             ex_branch_taken,
  input  logic             stall_cnt_clr,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic lu, mh, flush, stall, issue;

  assign lu = id_ex_memread_flag && (id_ex_rt != '0) &&
              ((if_id_use_rs && (if_id_rs == id_ex_rt)) ||
               (if_id_use_rt && (if_id_rt == id_ex_rt)));
  assign mh    = mdu_busy && (if_id_mdu_read || if_id_mdu_start);
  assign flush = ex_branch_taken;
  assign stall = !flush && (lu || mh);
  // A squashed or stalled mult/div must not start the countdown.
  assign issue = if_id_mdu_start && !stall && !flush;

  mdu_busy_timer #(.MDU_LATENCY(MDU_LATENCY)) u_mdu_timer (
    .clk      (clk),
    .rst      (rst),
    .issue    (issue),
    .mdu_busy (mdu_busy)
  );

  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    if (!rst) begin
      if (flush) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (stall) begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_bubble   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctr.sv
// Directed bench for hazard_ctr with MDU_LATENCY=4 and CNT_W=4.
module tb_hazard_ctr;
  import hazard_ctr_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  reg_idx_t   if_id_rs, if_id_rt, id_ex_rt;
  logic       if_id_use_rs, if_id_use_rt, if_id_mdu_read, if_id_mdu_start;
  logic       id_ex_memread_flag, ex_branch_taken, stall_cnt_clr;
  logic       pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, mdu_busy;
  logic [3:0] stall_cnt;

  int tests  = 0;
  int failed = 0;

  hazard_ctr #(.MDU_LATENCY(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_use_rs(if_id_use_rs), .if_id_use_rt(if_id_use_rt),
    .if_id_mdu_read(if_id_mdu_read), .if_id_mdu_start(if_id_mdu_start),
    .id_ex_rt(id_ex_rt), .id_ex_memread_flag(id_ex_memread_flag),
    .ex_branch_taken(ex_branch_taken), .stall_cnt_clr(stall_cnt_clr),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge, checks happen 1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_id_rs = '0; if_id_rt = '0; id_ex_rt = '0;
    if_id_use_rs = 0; if_id_use_rt = 0;
    if_id_mdu_read = 0; if_id_mdu_start = 0;
    id_ex_memread_flag = 0; ex_branch_taken = 0; stall_cnt_clr = 0;
  endtask

  // {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble}
  task automatic chk_ctl(input string name, input logic [3:0] exp);
    logic [3:0] got;
    #1;
    got = {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble};
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: ctl got %b expected %b", name, got, exp);
    end
  endtask

  localparam logic [3:0] RUN_V   = 4'b1100;
  localparam logic [3:0] STALL_V = 4'b0001;
  localparam logic [3:0] FLUSH_V = 4'b1111;

  task automatic clear_stats();
    stall_cnt_clr = 1;
    tick();
    stall_cnt_clr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #3;
    chk_ctl("reset_ctl", RUN_V);
    tests++;
    if (stall_cnt !== 4'd0 || mdu_busy !== 1'b0) begin
      failed++;
      $display("FAIL reset_state: stall_cnt=%0d mdu_busy=%b expected 0/0", stall_cnt, mdu_busy);
    end
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_load_use();
    clear_stats();
    id_ex_memread_flag = 1; id_ex_rt = 5'd5;
    if_id_rs = 5'd5; if_id_use_rs = 1; if_id_rt = 5'd7; if_id_use_rt = 1;
    chk_ctl("lu_rs_stall", STALL_V);
    tick();
    id_ex_memread_flag = 0;  // bubble now in ID/EX
    chk_ctl("lu_rs_next_run", RUN_V);
    tests++;
    if (stall_cnt !== 4'd1) begin
      failed++;
      $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt);
    end
    // rt path, then a matching rt that is not read
    id_ex_memread_flag = 1; id_ex_rt = 5'd9;
    if_id_rs = 5'd1; if_id_rt = 5'd9; if_id_use_rs = 1; if_id_use_rt = 1;
    chk_ctl("lu_rt_stall", STALL_V);
    if_id_use_rt = 0;
    chk_ctl("lu_rt_unused", RUN_V);
    id_ex_memread_flag = 0; if_id_use_rt = 1;
    chk_ctl("no_load_run", RUN_V);
    idle_inputs();
    tick();
  endtask

  task automatic test_zero_reg();
    clear_stats();
    id_ex_memread_flag = 1; id_ex_rt = 5'd0;
    if_id_rs = 5'd0; if_id_rt = 5'd0; if_id_use_rs = 1; if_id_use_rt = 1;
    chk_ctl("zero_reg_run", RUN_V);
    tick();
    tests++;
    if (stall_cnt !== 4'd0) begin
      failed++;
      $display("FAIL zero_reg_cnt: got %0d expected 0", stall_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_mdu();
    clear_stats();
    if_id_mdu_start = 1;  // cycle 0: mult issues
    chk_ctl("mult_issue_run", RUN_V);
    tick();
    if_id_mdu_start = 0; if_id_mdu_read = 1;
    for (int c = 1; c <= 4; c++) begin
      chk_ctl($sformatf("mflo_stall_c%0d", c), STALL_V);
      tests++;
      if (mdu_busy !== 1'b1) begin
        failed++;
        $display("FAIL mdu_busy_c%0d: got %b expected 1", c, mdu_busy);
      end
      tick();
    end
    chk_ctl("mflo_proceeds", RUN_V);
    tests++;
    if (mdu_busy !== 1'b0 || stall_cnt !== 4'd4) begin
      failed++;
      $display("FAIL mdu_done: busy=%b stall_cnt=%0d expected 0/4", mdu_busy, stall_cnt);
    end
    // mult squashed by flush never starts the count
    if_id_mdu_read = 0; if_id_mdu_start = 1; ex_branch_taken = 1;
    chk_ctl("mult_flushed", FLUSH_V);
    tick();
    if_id_mdu_start = 0; ex_branch_taken = 0;
    #1;
    tests++;
    if (mdu_busy !== 1'b0) begin
      failed++;
      $display("FAIL flushed_mult_busy: got %b expected 0", mdu_busy);
    end
    // back-to-back mult stalls while the first is running
    if_id_mdu_start = 1;
    tick();
    chk_ctl("mult_while_busy", STALL_V);
    idle_inputs();
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_flush_priority();
    clear_stats();
    id_ex_memread_flag = 1; id_ex_rt = 5'd5; if_id_rs = 5'd5; if_id_use_rs = 1;
    ex_branch_taken = 1;
    chk_ctl("flush_over_lu", FLUSH_V);
    tick();
    idle_inputs();
    #1;
    tests++;
    if (stall_cnt !== 4'd0) begin
      failed++;
      $display("FAIL flush_cnt: got %0d expected 0", stall_cnt);
    end
  endtask

  task automatic test_reset_mid_mdu();
    if_id_mdu_start = 1;
    tick();  // cnt=4
    if_id_mdu_start = 0;
    tick();  // cnt=3
    rst = 1;
    #1;
    tests++;
    if (mdu_busy !== 1'b0) begin
      failed++;
      $display("FAIL rst_mid_busy: got %b expected 0", mdu_busy);
    end
    tick();
    rst = 0;
    if_id_mdu_read = 1;
    chk_ctl("mfhi_after_rst", RUN_V);
    idle_inputs();
    tick();
  endtask

  task automatic test_saturation();
    clear_stats();
    id_ex_memread_flag = 1; id_ex_rt = 5'd3; if_id_rs = 5'd3; if_id_use_rs = 1;
    for (int i = 0; i < 14; i++) tick();
    tests++;
    if (stall_cnt !== 4'd14) begin
      failed++;
      $display("FAIL sat_14: got %0d expected 14", stall_cnt);
    end
    for (int i = 0; i < 6; i++) tick();
    tests++;
    if (stall_cnt !== 4'd15) begin
      failed++;
      $display("FAIL sat_hold: got %0d expected 15", stall_cnt);
    end
    stall_cnt_clr = 1;
    chk_ctl("sat_clr_still_stall", STALL_V);
    tick();
    tests++;
    if (stall_cnt !== 4'd0) begin
      failed++;
      $display("FAIL clr_over_inc: got %0d expected 0", stall_cnt);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_mdu();
    test_flush_priority();
    test_reset_mid_mdu();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
